dmac_bus_responder: RTL and testbench

- Bus-side counterpart of the DMAC master interface: arbitrates two requesters and serves their read/write transfers from an internal word memory.
- Port 0 connects to the DMAC master port (m_req/m_grant/m_wr/m_addr/m_dout/m_din).
- Port 1 is a host/test port that preloads source data and checks destination data.
- Arbitration is round-robin, non-preemptive; the owner keeps the bus for as long as it holds its request.

---
 rtl/dmac_bus_responder.sv | 160 ++++++++++++++++
 tb/tb_dmac_bus_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_bus_responder.sv
// Two-port bus responder for the DMAC: round-robin, non-preemptive arbitration
// in front of a single-ported word memory with registered per-port read data.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// OWN0  | port 0 owns the bus; transfers while m0_req=1
// OWN1  | port 1 owns the bus; transfers while m1_req=1
module dmac_bus_responder #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_grant,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_grant,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              addr_err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              addr_err_q, addr_err_d;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              xfer;
  logic              xfer_wr;
  logic              xfer_port;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_wdata;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  // Only the current owner's inputs ever reach the memory.
  always_comb begin
    xfer       = 1'b0;
    xfer_wr    = 1'b0;
    xfer_port  = 1'b0;
    xfer_addr  = '0;
    xfer_wdata = '0;
    case (state_q)
      OWN0: begin
        xfer       = m0_req;
        xfer_wr    = m0_wr;
        xfer_port  = 1'b0;
        xfer_addr  = m0_addr;
        xfer_wdata = m0_wdata;
      end
      OWN1: begin
        xfer       = m1_req;
        xfer_wr    = m1_wr;
        xfer_port  = 1'b1;
        xfer_addr  = m1_addr;
        xfer_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_range = ({1'b0, xfer_addr} < DEPTH_EXT);
    idx      = xfer_addr[IDX_W-1:0];
    rd_word  = in_range ? mem[idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset && xfer && xfer_wr && in_range) begin
      mem[idx] <= xfer_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          last_owner_d = 1'b0;
          state_d      = m1_req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          last_owner_d = 1'b1;
          state_d      = m0_req ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    addr_err_d = xfer && !in_range;
    if (xfer && !xfer_wr) begin
      if (xfer_port) begin
        m1_rdata_d = rd_word;
      end else begin
        m0_rdata_d = rd_word;
      end
    end
  end

  always_comb begin
    m0_grant = (state_q == OWN0);
    m1_grant = (state_q == OWN1);
    m0_rdata = m0_rdata_q;
    m1_rdata = m1_rdata_q;
    addr_err = addr_err_q;
  end

endmodule

// File: tb/tb_dmac_bus_responder.sv
// Bench for dmac_bus_responder: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dmac_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_grant, m1_grant, addr_err;

  dmac_bus_responder #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_grant(m0_grant), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_grant(m1_grant), .m1_rdata(m1_rdata),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit run_cmp    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: owner is -1 (nobody), 0 or 1.
  int          own  = -1;
  int          last = 1;
  logic [31:0] mem_m [256];
  logic [31:0] rd_m [2];
  logic        err_m = 1'b0;

  function automatic logic req_of(input int p);
    return (p == 1) ? m1_req : m0_req;
  endfunction

  always @(posedge clk) begin
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    if (reset) begin
      own = -1; last = 1; rd_m[0] = 0; rd_m[1] = 0; err_m = 0;
    end else begin
      err_m = 0;
      if (own >= 0 && req_of(own)) begin
        w = (own == 1) ? m1_wr : m0_wr;
        a = (own == 1) ? m1_addr : m0_addr;
        d = (own == 1) ? m1_wdata : m0_wdata;
        if (int'(a) < 256) begin
          if (w) mem_m[a[7:0]] = d;
          else   rd_m[own] = mem_m[a[7:0]];
        end else begin
          err_m = 1;
          if (!w) rd_m[own] = 0;
        end
      end else begin
        // Owner released (or none): prefer whichever port was not served last.
        if (own >= 0) last = own;
        if (req_of(1 - last))  own = 1 - last;
        else if (req_of(last)) own = last;
        else                   own = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("m0_grant", m0_grant, own == 0);
      check("m1_grant", m1_grant, own == 1);
      check("m0_rdata", m0_rdata, rd_m[0]);
      check("m1_rdata", m1_rdata, rd_m[1]);
      check("addr_err", addr_err, err_m);
    end
  end

  bit          vw [256];
  logic [15:0] va [256];
  logic [31:0] vd [256];
  logic [31:0] vr [256];
  logic        ve [256];
  int          gw;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic rq, input logic wr,
                          input logic [15:0] a, input logic [31:0] d);
    if (p == 1) begin
      m1_req = rq; m1_wr = wr; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = rq; m0_wr = wr; m0_addr = a; m0_wdata = d;
    end
  endtask

  function automatic logic grant_of(input int p);
    return (p == 1) ? m1_grant : m0_grant;
  endfunction

  task automatic burst(input int p, input int n, input bit drop);
    int w = 0;
    set_port(p, 1'b1, vw[0], va[0], vd[0]);
    do begin cyc(); w++; end while (!grant_of(p) && w < 50);
    gw = w;
    check("grant_wait", grant_of(p), 1);
    for (int i = 0; i < n; i++) begin
      set_port(p, 1'b1, vw[i], va[i], vd[i]);
      cyc();
      vr[i] = (p == 1) ? m1_rdata : m0_rdata;
      ve[i] = addr_err;
    end
    if (drop) begin
      set_port(p, 1'b0, 1'b0, 16'h0, 32'h0);
      cyc();
    end
  endtask

  initial begin
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(); cyc();
    run_cmp = 1;
    check("rst_g0", m0_grant, 0);
    check("rst_g1", m1_grant, 0);
    check("rst_rd0", m0_rdata, 0);
    check("rst_err", addr_err, 0);
    reset = 1'b0;

    // Preload every word through port 1.
    for (int i = 0; i < 256; i++) begin
      vw[i] = 1; va[i] = 16'(i); vd[i] = 32'h5500_0000 | i;
    end
    burst(1, 256, 1);

    // Port 0 write burst A0..A3, then port 1 reads them back.
    for (int i = 0; i < 4; i++) begin
      vw[i] = 1; va[i] = 16'(i); vd[i] = 32'hA0 + i;
    end
    burst(0, 4, 1);
    check("t1_grant_lat", gw, 1);
    for (int i = 0; i < 4; i++) begin
      vw[i] = 0; va[i] = 16'(i); vd[i] = 0;
    end
    burst(1, 4, 1);
    for (int i = 0; i < 4; i++) check("t1_readback", vr[i], 32'hA0 + i);

    // Tie after port 1 was last owner: port 0 first, then handoff.
    set_port(0, 1, 0, 16'h20, 0);
    set_port(1, 1, 0, 16'h21, 0);
    cyc();
    check("t2_tie_g0", m0_grant, 1);
    check("t2_tie_g1", m1_grant, 0);
    cyc();
    check("t2_rd0", m0_rdata, 32'h5500_0020);
    set_port(0, 0, 0, 0, 0);
    cyc();
    check("t2_hand_g1", m1_grant, 1);
    check("t2_hand_g0", m0_grant, 0);

    // Non-owner write attempt while port 1 owns.
    set_port(0, 1, 1, 16'h10, 32'hDEAD);
    cyc();
    check("t3_g0_held", m0_grant, 0);
    check("t3_rd1", m1_rdata, 32'h5500_0021);
    cyc();
    check("t3_g0_held2", m0_grant, 0);
    set_port(0, 0, 0, 0, 0);
    cyc();
    set_port(1, 0, 0, 0, 0);
    cyc();
    set_port(0, 1, 0, 16'h30, 0);
    set_port(1, 1, 0, 16'h31, 0);
    cyc();
    check("t2_tie2_g0", m0_grant, 1);
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    cyc();
    vw[0] = 0; va[0] = 16'h10;
    burst(1, 1, 1);
    check("t3_mem10", vr[0], 32'h5500_0010);

    // Read-after-write.
    vw[0] = 1; va[0] = 16'h5; vd[0] = 32'h1234;
    vw[1] = 0; va[1] = 16'h5; vd[1] = 0;
    burst(1, 2, 1);
    check("t4_raw", vr[1], 32'h1234);

    // Out-of-range read and write.
    vw[0] = 0; va[0] = 16'h0100; vd[0] = 0;
    vw[1] = 1; va[1] = 16'hFFFF; vd[1] = 32'hBEEF;
    vw[2] = 0; va[2] = 16'h00FF; vd[2] = 0;
    burst(1, 3, 1);
    check("t5_oor_rd", vr[0], 0);
    check("t5_err_rd", ve[0], 1);
    check("t5_err_wr", ve[1], 1);
    check("t5_mem_ff", vr[2], 32'h5500_00FF);
    check("t5_err_clr", ve[2], 0);

    // Reset in the middle of a port 0 burst.
    vw[0] = 0; va[0] = 16'h9; vd[0] = 0;
    burst(0, 1, 0);
    check("t6_pre_rd0", m0_rdata, 32'h5500_0009);
    set_port(0, 1, 1, 16'h7, 32'hBAD);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_g0", m0_grant, 0);
    check("t6_g1", m1_grant, 0);
    check("t6_rd0", m0_rdata, 0);
    set_port(0, 1, 0, 16'h7, 0);
    set_port(1, 1, 0, 16'h7, 0);
    cyc();
    check("t6_rearb_g0", m0_grant, 1);
    cyc();
    check("t6_mem7", m0_rdata, 32'h5500_0007);
    set_port(0, 0, 0, 0, 0);
    cyc();
    check("t6_hand_g1", m1_grant, 1);
    cyc();
    check("t6_mem7_p1", m1_rdata, 32'h5500_0007);
    set_port(1, 0, 0, 0, 0);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
